// File: rtl/adder_operand_fifo.sv
// ============================================================================
// Module  : adder_operand_fifo
// Brief   : Registered {A, B, Cin} operand FIFO feeding the carry-bypass adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_operand_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic                       out_cin,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

  logic [EW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;

  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic [EW-1:0]  w_head;

  // Ready is a function of registered count only, so a pop never opens a full FIFO.
  assign w_full    = (r_count == c_full_count);
  assign in_ready  = ~w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign w_head  = r_mem[r_rd_ptr];
  assign out_a   = out_valid ? w_head[EW-1:WIDTH+1] : '0;
  assign out_b   = out_valid ? w_head[WIDTH:1]      : '0;
  assign out_cin = out_valid ? w_head[0]            : 1'b0;

  assign count        = r_count;
  assign overflow_err = r_overflow;

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b, in_cin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire
